// File: rtl/tref_leak_dispatcher_pkg.sv
// rtl/tref_leak_dispatcher_pkg.sv - shared Tref sweep FSM encoding and neuron array defaults
package tref_leak_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } tref_state_t;

  // Neuron memory geometry; the memory and this dispatcher must agree on these.
  localparam int DEFAULT_NEURON_NUM = 256;
  localparam int DEFAULT_ADDR_W     = 8;

endpackage

// File: rtl/tref_overrun_counter.sv
// rtl/tref_overrun_counter.sv - saturating count of Tref ticks that arrived mid-sweep
module tref_overrun_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tref_leak_dispatcher.sv
// rtl/tref_leak_dispatcher.sv - acknowledges a Tref event and sweeps leak requests over all neurons
// Optional: define TREF_OVERRUN_CNT_EN to build the saturating overrun counter.
module tref_leak_dispatcher
  import tref_leak_dispatcher_pkg::*;
#(
  parameter int NEURON_NUM = DEFAULT_NEURON_NUM,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              tref_event_in,
  output logic              receive_tref,
  input  logic              spike_busy,
  output logic              leak_valid,
  output logic [ADDR_W-1:0] leak_addr,
  input  logic              leak_ready,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [CNT_W-1:0]  overrun_cnt
);

  tref_state_t       state, state_nxt;
  logic              leak_valid_nxt;
  logic [ADDR_W-1:0] leak_addr_nxt;
  logic              accept;
  logic              last_addr;

  assign accept    = leak_valid & leak_ready;
  assign last_addr = (leak_addr == ADDR_W'(NEURON_NUM - 1));

  // Every output is a flop; the status flags are decoded from the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      receive_tref <= 1'b0;
      sweep_busy   <= 1'b0;
      sweep_done   <= 1'b0;
      leak_valid   <= 1'b0;
      leak_addr    <= '0;
    end else begin
      state        <= state_nxt;
      receive_tref <= (state_nxt == ST_ACK);
      sweep_busy   <= (state_nxt != ST_IDLE);
      sweep_done   <= (state_nxt == ST_DONE);
      leak_valid   <= leak_valid_nxt;
      leak_addr    <= leak_addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tref_event_in && !spike_busy) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_SWEEP;
      ST_SWEEP: if (accept && last_addr) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A presented request is never withdrawn; spike_busy only gates starting a new one.
  always_comb begin
    leak_valid_nxt = leak_valid;
    leak_addr_nxt  = leak_addr;
    case (state)
      ST_ACK: begin
        leak_valid_nxt = 1'b0;
        leak_addr_nxt  = '0;
      end
      ST_SWEEP: begin
        if (accept) begin
          leak_valid_nxt = !last_addr && !spike_busy;
          leak_addr_nxt  = last_addr ? '0 : leak_addr + ADDR_W'(1);
        end else if (!leak_valid) begin
          leak_valid_nxt = !spike_busy;
        end
      end
      default: begin
        leak_valid_nxt = 1'b0;
      end
    endcase
  end

`ifdef TREF_OVERRUN_CNT_EN
  tref_overrun_counter #(
    .CNT_W(CNT_W)
  ) u_overrun (
    .CLK (CLK),
    .RST (RST),
    .inc ((state == ST_DONE) && tref_event_in),
    .cnt (overrun_cnt)
  );
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_tref_leak_dispatcher.sv
// tb/tb_tref_leak_dispatcher.sv - scoreboard bench for tref_leak_dispatcher with NEURON_NUM=4
module tb_tref_leak_dispatcher;

  localparam int N      = 4;
  localparam int AW     = 2;
  localparam int CW     = 2;
  localparam int EV_ACK  = 0;
  localparam int EV_LEAK = 1;
  localparam int EV_DONE = 2;
  localparam int BOUND   = 200;

  logic          CLK;
  logic          RST;
  logic          tref_event_in;
  logic          receive_tref;
  logic          spike_busy;
  logic          leak_valid;
  logic [AW-1:0] leak_addr;
  logic          leak_ready;
  logic          sweep_busy;
  logic          sweep_done;
  logic [CW-1:0] overrun_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tick_req = 0;
  int exp_ovr = 0;
  int sb_kind[$];
  int sb_val[$];

  tref_leak_dispatcher #(
    .NEURON_NUM(N),
    .ADDR_W(AW),
    .CNT_W(CW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .tref_event_in(tref_event_in),
    .receive_tref (receive_tref),
    .spike_busy   (spike_busy),
    .leak_valid   (leak_valid),
    .leak_addr    (leak_addr),
    .leak_ready   (leak_ready),
    .sweep_busy   (sweep_busy),
    .sweep_done   (sweep_done),
    .overrun_cnt  (overrun_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sweep();
    sb_kind.push_back(EV_ACK);
    sb_val.push_back(0);
    for (int a = 0; a < N; a++) begin
      sb_kind.push_back(EV_LEAK);
      sb_val.push_back(a);
    end
    sb_kind.push_back(EV_DONE);
    sb_val.push_back(0);
  endtask

  task automatic pop_cmp(input int kind, input int val);
    if (sb_kind.size() == 0) begin
      chk("sb_unexpected_event", kind, -1);
    end else begin
      chk("sb_kind", kind, sb_kind.pop_front());
      chk("sb_value", val, sb_val.pop_front());
    end
  endtask

  // Generator model: a set wins over a same-cycle acknowledge.
  initial begin
    int   tick_done;
    logic rcv;
    tick_done     = 0;
    tref_event_in = 1'b0;
    forever begin
      @(negedge CLK);
      rcv = receive_tref;
      @(posedge CLK);
      #2;
      if (tick_req != tick_done) begin
        tref_event_in = 1'b1;
        tick_done     = tick_req;
      end else if (rcv) begin
        tref_event_in = 1'b0;
      end
    end
  end

  initial begin
    logic          hold_pending;
    logic [AW-1:0] hold_addr;
    hold_pending = 1'b0;
    hold_addr    = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          chk("hold_valid", int'(leak_valid), 1);
          chk("hold_addr", int'(leak_addr), int'(hold_addr));
        end
        if (receive_tref) pop_cmp(EV_ACK, 0);
        if (leak_valid && leak_ready) pop_cmp(EV_LEAK, int'(leak_addr));
        if (sweep_done) pop_cmp(EV_DONE, 0);
        hold_pending = leak_valid && !leak_ready;
        hold_addr    = leak_addr;
      end
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!sweep_done && n < BOUND);
    if (!sweep_done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_addr(input int a, input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(leak_valid && int'(leak_addr) == a) && n < BOUND);
    if (!(leak_valid && int'(leak_addr) == a)) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic tick();
    tick_req++;
  endtask

  initial begin
    int t0;
    RST        = 1'b1;
    spike_busy = 1'b0;
    leak_ready = 1'b1;
    #3;
    chk("rst_receive_tref", int'(receive_tref), 0);
    chk("rst_leak_valid", int'(leak_valid), 0);
    chk("rst_leak_addr", int'(leak_addr), 0);
    chk("rst_sweep_busy", int'(sweep_busy), 0);
    chk("rst_sweep_done", int'(sweep_done), 0);
    chk("rst_overrun", int'(overrun_cnt), 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Basic sweep and latency
    @(posedge CLK);
    #1;
    push_sweep();
    tick();
    t0 = cyc;
    @(negedge CLK);
    @(negedge CLK);
    chk("ack_pulse", int'(receive_tref), 1);
    chk("ack_busy", int'(sweep_busy), 1);
    @(negedge CLK);
    chk("ack_one_cycle", int'(receive_tref), 0);
    wait_done("basic");
    chk("latency", cyc - t0, N + 3);
    chk("done_busy", int'(sweep_busy), 1);
    @(negedge CLK);
    chk("done_one_cycle", int'(sweep_done), 0);
    chk("idle_busy", int'(sweep_busy), 0);
    chk("idle_valid", int'(leak_valid), 0);

    // Event pending while spike_busy
    @(posedge CLK);
    #1;
    spike_busy = 1'b1;
    tick();
    push_sweep();
    repeat (5) begin
      @(negedge CLK);
      chk("no_ack_while_busy", int'(receive_tref), 0);
    end
    @(posedge CLK);
    #1 spike_busy = 1'b0;
    @(negedge CLK);
    chk("ack_not_yet", int'(receive_tref), 0);
    @(negedge CLK);
    chk("ack_after_busy", int'(receive_tref), 1);
    wait_done("busy_arrival");

    // Backpressure at addr 2 with spike_busy rising meanwhile
    @(posedge CLK);
    #1;
    tick();
    push_sweep();
    wait_addr(1, "bp");
    @(posedge CLK);
    #1;
    leak_ready = 1'b0;
    spike_busy = 1'b1;
    repeat (2) @(posedge CLK);
    #1 leak_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("pause_valid", int'(leak_valid), 0);
    chk("pause_addr", int'(leak_addr), 3);
    repeat (2) begin
      @(negedge CLK);
      chk("pause_hold_valid", int'(leak_valid), 0);
      chk("pause_hold_addr", int'(leak_addr), 3);
    end
    @(posedge CLK);
    #1 spike_busy = 1'b0;
    wait_done("bp");

    // Second tick during a sweep
    @(posedge CLK);
    #1;
    tick();
    push_sweep();
    wait_addr(1, "double");
    @(posedge CLK);
    #1;
    tick();
    push_sweep();
    wait_done("double_first");
`ifdef TREF_OVERRUN_CNT_EN
    exp_ovr = 1;
`endif
    @(negedge CLK);
    chk("double_idle", int'(sweep_busy), 0);
    chk("double_overrun", int'(overrun_cnt), exp_ovr);
    @(negedge CLK);
    chk("double_reack", int'(receive_tref), 1);
    wait_done("double_second");

    // Reset mid-sweep
    @(posedge CLK);
    #1;
    tick();
    push_sweep();
    wait_addr(2, "rst_mid");
    #1 RST = 1'b1;
    #1;
    chk("arst_valid", int'(leak_valid), 0);
    chk("arst_addr", int'(leak_addr), 0);
    chk("arst_busy", int'(sweep_busy), 0);
    chk("arst_done", int'(sweep_done), 0);
    chk("arst_receive", int'(receive_tref), 0);
    chk("arst_overrun", int'(overrun_cnt), 0);
    sb_kind.delete();
    sb_val.delete();
    exp_ovr = 0;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
    tick();
    push_sweep();
    wait_done("restart");

    // Overrun saturation: five ticks landing mid-sweep
    @(posedge CLK);
    #1;
    tick();
    push_sweep();
    for (int i = 0; i < 5; i++) begin
      wait_addr(1, "sat");
      @(posedge CLK);
      #1;
      tick();
      push_sweep();
      wait_done("sat_mid");
    end
    wait_done("sat_last");
`ifdef TREF_OVERRUN_CNT_EN
    exp_ovr = 3;
`endif
    @(negedge CLK);
    chk("overrun_saturate", int'(overrun_cnt), exp_ovr);

    repeat (3) @(negedge CLK);
    chk("sb_drained", sb_kind.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
